// File: rtl/simd_pkg.sv
// Shared SIMD definitions: lane geometry, collector FSM states, lane slice helper.
package simd_pkg;

  localparam int unsigned LANE_W    = 32;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned BEAT_W    = LANE_W * NUM_LANES;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RES_BEAT = 2'd1,
    EXT_BEAT = 2'd2
  } rc_state_t;

  // Lane 0 sits in the most significant word of a beat.
  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned lanes,
                                           input int unsigned lane_w);
    return (lanes - 1 - lane) * lane_w;
  endfunction

endpackage

// File: rtl/simd_result_collector_mem.sv
// Capture storage for simd_result_collector: DEPTH entries, one write port, async read.
module rc_fifo_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/simd_result_collector.sv
// Buffers SIMD lane captures and streams each as a result beat then an extra beat.
// Optional RC_ZERO_MASK_EN adds the per-lane zero flag output rc_out_zero.
module simd_result_collector #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LANE_W    = simd_pkg::LANE_W,
  parameter int unsigned NUM_LANES = simd_pkg::NUM_LANES,
  parameter int unsigned BW        = NUM_LANES * LANE_W,
  parameter int unsigned CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rc_done,
  input  logic [BW-1:0] rc_result_in,
  input  logic [BW-1:0] rc_extra_in,
  input  logic          rc_clear,
  output logic [BW-1:0] rc_out_data,
  output logic          rc_out_valid,
  input  logic          rc_out_ready,
  output logic          rc_out_last,
  output logic [CW-1:0] rc_count,
  output logic          rc_full,
  output logic          rc_empty,
  output logic          rc_overflow
`ifdef RC_ZERO_MASK_EN
  ,
  output logic [NUM_LANES-1:0] rc_out_zero
`endif
);
  import simd_pkg::*;

  localparam int unsigned     PW       = $clog2(DEPTH);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  rc_state_t       r_state, w_state_next;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr, w_raddr;
  logic [CW-1:0]   r_count, w_count_next;
  logic            r_done_q, r_overflow, r_out_valid, r_out_last;
  logic [BW-1:0]   r_out_data, w_data_next, w_rd_res, w_rd_ext;
  logic            w_valid_next, w_last_next, w_capture, w_pop, w_we;
  logic [2*BW-1:0] w_rdata;

  rc_fifo_mem #(.DEPTH(DEPTH), .WIDTH(2*BW), .AW(PW)) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_wr_ptr),
    .wdata ({rc_result_in, rc_extra_in}),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  assign w_rd_res = w_rdata[2*BW-1:BW];
  assign w_rd_ext = w_rdata[BW-1:0];

  always_comb begin
    w_capture    = rc_done & ~r_done_q;
    w_pop        = (r_state == EXT_BEAT) & r_out_valid & rc_out_ready;
    w_we         = w_capture & ((r_count != FULL_CNT) | w_pop) & ~rc_clear;
    w_count_next = r_count;
    if (w_we & ~w_pop)      w_count_next = r_count + CW'(1);
    else if (~w_we & w_pop) w_count_next = r_count - CW'(1);
    // During the extra beat the read port looks ahead to the next head entry.
    w_raddr = (r_state == EXT_BEAT) ? r_rd_ptr + PW'(1) : r_rd_ptr;
  end

  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_out_data;
    w_valid_next = r_out_valid;
    w_last_next  = r_out_last;
    unique case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_state_next = RES_BEAT;
          w_data_next  = w_rd_res;
          w_valid_next = 1'b1;
          w_last_next  = 1'b0;
        end
      end
      RES_BEAT: begin
        if (r_out_valid & rc_out_ready) begin
          w_state_next = EXT_BEAT;
          w_data_next  = w_rd_ext;
          w_last_next  = 1'b1;
        end
      end
      EXT_BEAT: begin
        if (w_pop) begin
          if (w_count_next != '0) begin
            // Single stored entry plus a same-cycle write: bypass the incoming word.
            w_state_next = RES_BEAT;
            w_data_next  = (r_count == CW'(1)) ? rc_result_in : w_rd_res;
            w_last_next  = 1'b0;
          end else begin
            w_state_next = IDLE;
            w_valid_next = 1'b0;
            w_last_next  = 1'b0;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef RC_ZERO_MASK_EN
  logic [NUM_LANES-1:0] r_out_zero, w_zero_next;

  always_comb begin
    w_zero_next = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++)
      w_zero_next[NUM_LANES-1-i] =
        (w_data_next[lane_lsb(i, NUM_LANES, LANE_W) +: LANE_W] == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset || rc_clear) r_out_zero <= '0;
    else                    r_out_zero <= w_zero_next;
  end

  assign rc_out_zero = r_out_zero;
`endif

  always_ff @(posedge clk) begin
    if (!reset) r_done_q <= 1'b0;
    else        r_done_q <= rc_done;
  end

  always_ff @(posedge clk) begin
    if (!reset || rc_clear) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_out_data  <= w_data_next;
      r_out_valid <= w_valid_next;
      r_out_last  <= w_last_next;
      if (w_we)              r_wr_ptr   <= r_wr_ptr + PW'(1);
      if (w_pop)             r_rd_ptr   <= r_rd_ptr + PW'(1);
      if (w_capture & ~w_we) r_overflow <= 1'b1;
    end
  end

  assign rc_out_data  = r_out_data;
  assign rc_out_valid = r_out_valid;
  assign rc_out_last  = r_out_last;
  assign rc_count     = r_count;
  assign rc_full      = (r_count == FULL_CNT);
  assign rc_empty     = (r_count == '0);
  assign rc_overflow  = r_overflow;

endmodule
